// File: rtl/aes_pkg.sv
// Shared AES definitions: inverse S-box, GF(2^8) multiply helpers, FSM state enum and sizes.
package aes_pkg;

  localparam int NB   = 4;
  localparam int NK   = 4;
  localparam int NR   = 10;
  localparam int KS_W = 1408;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Entry for input byte b sits at bits [2047-8*b -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] x9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] xb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] xd(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] xe(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/decrypt_round.sv
// One combinational InvCipher round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last is set.
module decrypt_round
  import aes_pkg::*;
(
  input  logic [127:0] in,
  input  logic [127:0] key,
  input  logic         last,
  output logic [127:0] out
);

  logic [127:0] sub_q;
  logic [127:0] ark;
  logic [127:0] mix;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    sub_q = '0;
    mix   = '0;
    a0    = '0;
    a1    = '0;
    a2    = '0;
    a3    = '0;
    // Byte r+4c is row r, column c; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_q[127-8*(r+4*c) -: 8] = inv_sbox(in[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    ark = sub_q ^ key;
    for (int c = 0; c < 4; c++) begin
      a0 = ark[127-32*c -: 8];
      a1 = ark[119-32*c -: 8];
      a2 = ark[111-32*c -: 8];
      a3 = ark[103-32*c -: 8];
      mix[127-32*c -: 8] = xe(a0) ^ xb(a1) ^ xd(a2) ^ x9(a3);
      mix[119-32*c -: 8] = x9(a0) ^ xe(a1) ^ xb(a2) ^ xd(a3);
      mix[111-32*c -: 8] = xd(a0) ^ x9(a1) ^ xe(a2) ^ xb(a3);
      mix[103-32*c -: 8] = xb(a0) ^ xd(a1) ^ x9(a2) ^ xe(a3);
    end
    out = last ? ark : mix;
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 InvCipher, one round per clock. Define AES_INV_CIPHER_KEY_LATCH_EN
// to capture the key schedule at accept so w may change while busy.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// out_valid/out hold stable until taken, and valid never depends on ready.
module aes_inv_cipher #(
  parameter int NR = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [127:0]             in,
  input  logic [aes_pkg::KS_W-1:0] w,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out
);
  import aes_pkg::*;

  aes_state_e   fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] out_q, out_d;
  logic         ov_q, ov_d;
  logic [KS_W-1:0] ks;
  logic [127:0] rkey;
  logic [127:0] round_out;

`ifdef AES_INV_CIPHER_KEY_LATCH_EN
  logic [KS_W-1:0] w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          w_q <= '0;
    else if (fsm_q == IDLE && in_valid)  w_q <= w;
  end
  assign ks = w_q;
`else
  assign ks = w;
`endif

  // Round key r lives at the top of w for r = 0 and at the bottom for r = NR.
  assign rkey = ks[KS_W-1-128*int'(rnd_q) -: 128];

  decrypt_round u_round (
    .in   (st_q),
    .key  (rkey),
    .last (rnd_q == 4'd0),
    .out  (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      st_q  <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
      out_q <= out_d;
      ov_q  <= ov_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d  = st_q;
    out_d = out_q;
    ov_d  = ov_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = in ^ w[127:0];
          rnd_d = 4'(NR - 1);
          fsm_d = RUN;
        end
      end
      RUN: begin
        st_d = round_out;
        if (rnd_q == 4'd0) begin
          out_d = round_out;
          ov_d  = 1'b1;
          fsm_d = DONE;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d  = 1'b0;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = ov_q;
  assign out       = out_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher using the FIPS-197 C.1 vector; the key schedule
// is expanded here from first principles (GF inverse + affine S-box).
module tb_aes_inv_cipher;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in;
  logic [1407:0]  w;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out;

  logic [1407:0]  ks_good;
  logic [127:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;

  aes_inv_cipher #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference key expansion ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++)
      if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] k);
    logic [31:0]   wd[44];
    logic [31:0]   t;
    logic [7:0]    rcon = 8'h01;
    logic [1407:0] r = '0;
    for (int i = 0; i < 4; i++) wd[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = wd[i-1];
      if (i % 4 == 0) begin
        t = {sbox_fwd(t[23:16]), sbox_fwd(t[15:8]), sbox_fwd(t[7:0]), sbox_fwd(t[31:24])};
        t = t ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      wd[i] = wd[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = wd[i];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] ct);
    in       = ct;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in = '0; w = ks_good;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b out=%h, want 0 and 0", out_valid, out);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_c1();
    int lat;
    start_block(CT);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL c1_busy_ready: in_ready=%b, want 0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat != 10) begin
      errors++;
      $display("FAIL c1_latency: latency=%0d edges, want 10", lat);
    end
    checks++;
    if (out !== PT) begin
      errors++;
      $display("FAIL c1_data: out=%h, want %h", out, PT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL c1_handshake: out_valid=%b in_ready=%b, want 0 and 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    start_block(CT);
    wait_out(lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in       = ~CT;
      tick();
      if (out_valid !== 1'b1 || out !== PT || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d of 20 cycles unstable, want 0", bad);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 and 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out !== PT) begin
      errors++;
      $display("FAIL bp_out_held: out=%h, want %h", out, PT);
    end
  endtask

  task automatic test_busy_drop();
    logic early = 1'b0;
    start_block(CT);
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) begin in_valid = 1'b1; in = 128'hdeadbeef_00000000_cafef00d_12345678; end
      if (k == 8) in_valid = 1'b0;
      tick();
      if (k < 10 && out_valid) early = 1'b1;
    end
    checks++;
    if (early || out_valid !== 1'b1 || out !== PT) begin
      errors++;
      $display("FAIL busy_drop: early=%b out_valid=%b out=%h, want 0 1 %h", early, out_valid, out, PT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    int leaks = 0;
    start_block(CT);
    for (int k = 1; k <= 4; k++) tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: out_valid=%b out=%h, want 0 and 0", out_valid, out);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: in_ready=%b, want 1", in_ready);
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid !== 1'b0) leaks++;
    end
    checks++;
    if (leaks != 0) begin
      errors++;
      $display("FAIL mid_reset_leak: out_valid seen %0d cycles, want 0", leaks);
    end
    start_block(CT);
    wait_out(lat);
    checks++;
    if (lat != 10 || out !== PT) begin
      errors++;
      $display("FAIL mid_reset_rerun: latency=%0d out=%h, want 10 %h", lat, out, PT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int n_out = 0;
    logic [127:0] exp;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in        = CT;
    for (int i = 0; i < 24; i++) begin
      if (in_ready) begin
        acc_cyc.push_back(i);
        exp_q.push_back(PT);
      end
      tick();
      if (out_valid) begin
        n_out++;
        checks++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~PT;
        if (out !== exp) begin
          errors++;
          $display("FAIL b2b_data%0d: out=%h, want %h", n_out, out, exp);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (acc_cyc.size() != 2 || n_out != 2) begin
      errors++;
      $display("FAIL b2b_counts: accepts=%0d outputs=%0d, want 2 and 2", acc_cyc.size(), n_out);
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 12) begin
        errors++;
        $display("FAIL b2b_interval: interval=%0d, want 12", acc_cyc[1] - acc_cyc[0]);
      end
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_key_latch();
`ifdef AES_INV_CIPHER_KEY_LATCH_EN
    int lat;
    start_block(CT);
    w = ~ks_good;
    wait_out(lat);
    checks++;
    if (lat != 10 || out !== PT) begin
      errors++;
      $display("FAIL key_latch: latency=%0d out=%h, want 10 %h", lat, out, PT);
    end
    w = ks_good;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`else
    $display("note: key-latch scenario skipped; changing w while busy is a protocol violation in this build");
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ks_good = expand_key(KEY);
    w = ks_good;
    test_reset();
    test_c1();
    test_backpressure();
    test_busy_drop();
    test_reset_mid();
    test_back_to_back();
    test_key_latch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
